regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Write-side front end for the MIPS register file.
- Accepts register write requests from the execute, load and multiply paths through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file's RegWrite/WriteReg/WriteData inputs.
- Gives the decode stage pending-write status and bypass data for its two read addresses, covering writes the register file has not yet absorbed.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- CW, 3, width of Count; must hold 0..DEPTH.

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- InValid  input  1  write request valid
- InReady  output  1  queue can accept; high when Count < DEPTH
- InReg  input  5  destination register index
- InData  input  32  destination value
- DrainHold  input  1  when high, no entry is popped this cycle
- RegWrite  output  1  register file write enable (registered)
- WriteReg  output  5  register file write index (registered)
- WriteData  output  32  register file write data (registered)
- ReadReg1  input  5  decode read address 1
- ReadReg2  input  5  decode read address 2
- Pending1  output  1  ReadReg1 has an outstanding write (combinational)
- Pending2  output  1  ReadReg2 has an outstanding write (combinational)
- BypassData1  output  32  youngest outstanding value for ReadReg1; 0 when Pending1=0
- BypassData2  output  32  youngest outstanding value for ReadReg2; 0 when Pending2=0
- Count  output  CW  occupied FIFO entries (output stage excluded)
- Empty  output  1  Count==0 and RegWrite==0

Behaviour:
- Reset (async, any cycle including mid-drain):
  - head, tail and Count go to 0; all entry valid bits are cleared.
  - RegWrite=0, WriteReg=0, WriteData=0.
  - Pending outputs read 0; InReady=1.
- Push:
  - Occurs on a rising edge when InValid && InReady.
  - The entry {InReg, InData} goes in at tail; tail wraps modulo DEPTH.
  - InReady does not depend combinationally on pop. A full queue rejects the request even in a cycle that pops.
- Filtered pushes: InReg==0 or InReg==28 ($gp is held constant by the register file).
  - The request is accepted (handshake completes) and then discarded.
  - It does not change Count and never reaches RegWrite.
- Pop:
  - Occurs on each rising edge where Count>0 and !DrainHold.
  - The head entry is loaded into the output stage with RegWrite=1; head wraps modulo DEPTH.
  - On any other edge, RegWrite goes to 0 and WriteReg/WriteData hold their values.
- Simultaneous push and pop: both occur and Count is unchanged.
- Latency: a request accepted at edge N into an empty queue, with DrainHold=0, drives RegWrite=1 during cycle N+1→N+2. The register file captures it at edge N+2.
- Ordering: strict FIFO. Two writes to the same register retire in acceptance order.
- Lookup, combinational, applied to each read port independently:
  - The search covers all valid FIFO entries plus the output stage when RegWrite=1.
  - PendingX=1 if any of these match ReadRegX.
  - BypassDataX takes the youngest match. Priority order is tail-1 down to head, then the output stage.
  - ReadRegX==0 always gives PendingX=0 and BypassDataX=0.
- Count wrap: Count never exceeds DEPTH; pushes at DEPTH are blocked by InReady=0.

Optional Feature:
- Macro: WQ_COALESCE_EN.
- Defined:
  - A push whose InReg matches a valid FIFO entry overwrites that entry's data in place. Count does not increment, and this is allowed even when full.
  - InReady becomes 1 when Count<DEPTH or InReg matches a valid entry.
  - Exception: if the match is the head entry and that entry is being popped this same edge, the push allocates a new entry instead (normal rules apply).
  - Entries in the output stage are never coalesced.
- Undefined: every accepted non-filtered push allocates its own entry, exactly as described in Behaviour.

Test Plan:
- Reset, then push {5, 0xDEADBEEF} at edge 1, DrainHold=0 → RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF during cycle 2; Empty=1 from cycle 3.
- DrainHold=1, push regs 1,2,3,4 with data 0x11,0x22,0x33,0x44 → Count=4, InReady=0, a fifth push is not accepted. Release DrainHold → four consecutive RegWrite pulses in order 1,2,3,4.
- DrainHold=1, push {7,0xA} then {7,0xB}, ReadReg1=7, ReadReg2=8 → Pending1=1, BypassData1=0xB, Pending2=0, BypassData2=0. With the macro defined, Count=1.
- Push {0,0x55} and {28,0x66} → InReady stays 1 and both handshakes complete; Count stays 0; RegWrite never asserts; Pending=0 for ReadReg 0 and 28.
- Queue holds 3 entries, push and pop on the same edge → Count stays 3. Assert Reset mid-drain → RegWrite=0, Count=0, Pending1/2=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/regfile_write_queue.sv
// Write-side front end for the MIPS register file: buffers write requests in a FIFO,
// retires one per cycle, and gives decode pending/bypass info. Optional macro: WQ_COALESCE_EN.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InReg,
  input  logic [31:0]   InData,
  input  logic          DrainHold,
  output logic          RegWrite,
  output logic [4:0]    WriteReg,
  output logic [31:0]   WriteData,
  input  logic [4:0]    ReadReg1,
  input  logic [4:0]    ReadReg2,
  output logic          Pending1,
  output logic          Pending2,
  output logic [31:0]   BypassData1,
  output logic [31:0]   BypassData2,
  output logic [CW-1:0] Count,
  output logic          Empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       regQ  [DEPTH];
  logic [31:0]      dataQ [DEPTH];
  logic [DEPTH-1:0] validQ, validD;
  logic [AW-1:0]    headQ, headD;
  logic [AW-1:0]    tailQ, tailD;
  logic [CW-1:0]    countQ, countD;
  logic             outValidQ, outValidD;
  logic [4:0]       outRegQ, outRegD;
  logic [31:0]      outDataQ, outDataD;

  logic filtered;
  logic pushFire;
  logic popFire;
  logic alloc;

  // $zero and $gp are never written by the register file, so such requests are swallowed
  assign filtered = (InReg == 5'd0) || (InReg == 5'd28);
  assign popFire  = (countQ != '0) && !DrainHold;
  assign pushFire = InValid && InReady;

`ifdef WQ_COALESCE_EN
  logic          matchAny;
  logic [AW-1:0] matchIdx;
  logic          coalesce;

  always_comb begin
    matchAny = 1'b0;
    matchIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validQ[i] && (regQ[i] == InReg)) begin
        matchAny = 1'b1;
        matchIdx = AW'(i);
      end
    end
  end

  // A match on the head that leaves this edge cannot absorb the write; it gets a fresh slot
  assign coalesce = pushFire && !filtered && matchAny && !(popFire && (matchIdx == headQ));
  assign InReady  = (countQ < CW'(DEPTH)) || matchAny;
  assign alloc    = pushFire && !filtered && !coalesce;
`else
  assign InReady  = (countQ < CW'(DEPTH));
  assign alloc    = pushFire && !filtered;
`endif

  always_comb begin
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ;
    validD = validQ;
    if (popFire) begin
      validD[headQ] = 1'b0;
      headD         = headQ + 1'b1;
    end
    if (alloc) begin
      validD[tailQ] = 1'b1;
      tailD         = tailQ + 1'b1;
    end
    case ({alloc, popFire})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

  always_comb begin
    outValidD = popFire;
    outRegD   = outRegQ;
    outDataD  = outDataQ;
    if (popFire) begin
      outRegD  = regQ[headQ];
      outDataD = dataQ[headQ];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      headQ     <= '0;
      tailQ     <= '0;
      countQ    <= '0;
      validQ    <= '0;
      outValidQ <= 1'b0;
      outRegQ   <= '0;
      outDataQ  <= '0;
    end else begin
      headQ     <= headD;
      tailQ     <= tailD;
      countQ    <= countD;
      validQ    <= validD;
      outValidQ <= outValidD;
      outRegQ   <= outRegD;
      outDataQ  <= outDataD;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regQ[i]  <= '0;
        dataQ[i] <= '0;
      end
    end else begin
      if (alloc) begin
        regQ[tailQ]  <= InReg;
        dataQ[tailQ] <= InData;
      end
`ifdef WQ_COALESCE_EN
      if (coalesce) begin
        dataQ[matchIdx] <= InData;
      end
`endif
    end
  end

  // Walk oldest to youngest so the last hit wins; the output stage is older than any entry
  always_comb begin
    logic [AW-1:0] slot;
    slot        = '0;
    Pending1    = 1'b0;
    Pending2    = 1'b0;
    BypassData1 = '0;
    BypassData2 = '0;
    if (outValidQ && (outRegQ == ReadReg1)) begin
      Pending1    = 1'b1;
      BypassData1 = outDataQ;
    end
    if (outValidQ && (outRegQ == ReadReg2)) begin
      Pending2    = 1'b1;
      BypassData2 = outDataQ;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = headQ + AW'(k);
      if (validQ[slot] && (regQ[slot] == ReadReg1)) begin
        Pending1    = 1'b1;
        BypassData1 = dataQ[slot];
      end
      if (validQ[slot] && (regQ[slot] == ReadReg2)) begin
        Pending2    = 1'b1;
        BypassData2 = dataQ[slot];
      end
    end
    if (ReadReg1 == 5'd0) begin
      Pending1    = 1'b0;
      BypassData1 = '0;
    end
    if (ReadReg2 == 5'd0) begin
      Pending2    = 1'b0;
      BypassData2 = '0;
    end
  end

  assign RegWrite  = outValidQ;
  assign WriteReg  = outRegQ;
  assign WriteData = outDataQ;
  assign Count     = countQ;
  assign Empty     = (countQ == '0) && !outValidQ;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed, table-driven bench for regfile_write_queue (default build, DEPTH=4).
module tb_regfile_write_queue;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InReg;
  logic [31:0] InData;
  logic        DrainHold;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        Pending1;
  logic        Pending2;
  logic [31:0] BypassData1;
  logic [31:0] BypassData2;
  logic [2:0]  Count;
  logic        Empty;

  int compared;
  int mismatched;

  typedef struct {
    logic        inValid;
    logic [4:0]  inReg;
    logic [31:0] inData;
    logic        drainHold;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        expReady;
    logic        expRw;
    logic [4:0]  expWr;
    logic [31:0] expWd;
    logic        expP1;
    logic [31:0] expB1;
    logic        expP2;
    logic [31:0] expB2;
    logic [2:0]  expCount;
    logic        expEmpty;
  } vec_t;

  vec_t vecs[$];

  regfile_write_queue #(.DEPTH(4), .CW(3)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InData(InData), .DrainHold(DrainHold),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .Pending1(Pending1), .Pending2(Pending2),
    .BypassData1(BypassData1), .BypassData2(BypassData2),
    .Count(Count), .Empty(Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ir, input logic [31:0] id, input logic dh,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic rdy, input logic rw, input logic [4:0] wr, input logic [31:0] wd,
    input logic p1, input logic [31:0] b1, input logic p2, input logic [31:0] b2,
    input logic [2:0] cnt, input logic emp);
    vec_t v;
    v.inValid = iv;  v.inReg = ir;   v.inData = id;  v.drainHold = dh;
    v.rr1 = r1;      v.rr2 = r2;
    v.expReady = rdy; v.expRw = rw;  v.expWr = wr;   v.expWd = wd;
    v.expP1 = p1;    v.expB1 = b1;   v.expP2 = p2;   v.expB2 = b2;
    v.expCount = cnt; v.expEmpty = emp;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    InValid   = v.inValid;
    InReg     = v.inReg;
    InData    = v.inData;
    DrainHold = v.drainHold;
    ReadReg1  = v.rr1;
    ReadReg2  = v.rr2;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, ".InReady"},     32'(InReady),     32'(v.expReady));
    checkField({tag, ".RegWrite"},    32'(RegWrite),    32'(v.expRw));
    checkField({tag, ".WriteReg"},    32'(WriteReg),    32'(v.expWr));
    checkField({tag, ".WriteData"},   WriteData,        v.expWd);
    checkField({tag, ".Pending1"},    32'(Pending1),    32'(v.expP1));
    checkField({tag, ".BypassData1"}, BypassData1,      v.expB1);
    checkField({tag, ".Pending2"},    32'(Pending2),    32'(v.expP2));
    checkField({tag, ".BypassData2"}, BypassData2,      v.expB2);
    checkField({tag, ".Count"},       32'(Count),       32'(v.expCount));
    checkField({tag, ".Empty"},       32'(Empty),       32'(v.expEmpty));
  endtask

  initial begin
    vec_t v;
    compared   = 0;
    mismatched = 0;

    // Single write latency, then a full queue drained in order
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 5, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 5, 0, 1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 5, 0, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 5, 0, 1, 0, 5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 1,  32'h11,       1, 1, 2, 1, 0, 5, 32'hDEADBEEF, 0, 32'h0,  0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 2,  32'h22,       1, 1, 2, 1, 0, 5, 32'hDEADBEEF, 1, 32'h11, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 3,  32'h33,       1, 3, 2, 1, 0, 5, 32'hDEADBEEF, 0, 32'h0,  1, 32'h22, 2, 0));
    vecs.push_back(mk(1, 4,  32'h44,       1, 3, 4, 1, 0, 5, 32'hDEADBEEF, 1, 32'h33, 0, 32'h0,  3, 0));
    vecs.push_back(mk(1, 9,  32'h99,       1, 4, 9, 0, 0, 5, 32'hDEADBEEF, 1, 32'h44, 0, 32'h0,  4, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 9, 1, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0,  1, 32'h11, 4, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 1, 4, 0, 0, 5, 32'hDEADBEEF, 1, 32'h11, 1, 32'h44, 4, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 1, 0, 1, 1, 1, 32'h11,       1, 32'h11, 0, 32'h0,  3, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 1, 2, 1, 1, 2, 32'h22,       0, 32'h0,  1, 32'h22, 2, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 0, 1, 1, 3, 32'h33,       0, 32'h0,  0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 0, 1, 1, 4, 32'h44,       0, 32'h0,  0, 32'h0,  0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 0, 1, 0, 4, 32'h44,       0, 32'h0,  0, 32'h0,  0, 1));
    // Same register twice: youngest value wins, including over the output stage
    vecs.push_back(mk(1, 7,  32'hA,        1, 7, 8, 1, 0, 4, 32'h44, 0, 32'h0, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 7,  32'hB,        1, 7, 8, 1, 0, 4, 32'h44, 1, 32'hA, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 7, 8, 1, 0, 4, 32'h44, 1, 32'hB, 0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7, 8, 1, 0, 4, 32'h44, 1, 32'hB, 0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7, 8, 1, 1, 7, 32'hA,  1, 32'hB, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7, 8, 1, 1, 7, 32'hB,  1, 32'hB, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7, 8, 1, 0, 7, 32'hB,  0, 32'h0, 0, 32'h0, 0, 1));
    // Filtered destinations $zero and $gp
    vecs.push_back(mk(1, 0,  32'h55,       0, 0, 28, 1, 0, 7, 32'hB, 0, 32'h0, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 28, 32'h66,       0, 0, 28, 1, 0, 7, 32'hB, 0, 32'h0, 0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 28, 1, 0, 7, 32'hB, 0, 32'h0, 0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 28, 1, 0, 7, 32'hB, 0, 32'h0, 0, 32'h0, 0, 1));
    // Three queued, then simultaneous push and pop
    vecs.push_back(mk(1, 10, 32'h100,      1, 10, 11, 1, 0, 7,  32'hB,   0, 32'h0,   0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 11, 32'h101,      1, 10, 11, 1, 0, 7,  32'hB,   1, 32'h100, 0, 32'h0,   1, 0));
    vecs.push_back(mk(1, 12, 32'h102,      1, 10, 11, 1, 0, 7,  32'hB,   1, 32'h100, 1, 32'h101, 2, 0));
    vecs.push_back(mk(1, 13, 32'h103,      0, 12, 13, 1, 0, 7,  32'hB,   1, 32'h102, 0, 32'h0,   3, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 10, 13, 1, 1, 10, 32'h100, 1, 32'h100, 1, 32'h103, 3, 0));

    Reset = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d", i), vecs[i]);
    end

    // Drain one entry, then hit Reset between clock edges
    @(negedge Clk);
    applyStimulus(mk(0, 0, 0, 0, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk);
    #1;
    checkField("drain.RegWrite",  32'(RegWrite), 32'd1);
    checkField("drain.WriteReg",  32'(WriteReg), 32'd11);
    checkField("drain.WriteData", WriteData,     32'h101);
    checkField("drain.Count",     32'(Count),    32'd2);
    checkField("drain.Pending1",  32'(Pending1), 32'd1);
    #1 Reset = 1'b1;
    #1;
    checkField("rst.RegWrite",  32'(RegWrite),  32'd0);
    checkField("rst.WriteReg",  32'(WriteReg),  32'd0);
    checkField("rst.WriteData", WriteData,      32'h0);
    checkField("rst.Count",     32'(Count),     32'd0);
    checkField("rst.Pending1",  32'(Pending1),  32'd0);
    checkField("rst.Pending2",  32'(Pending2),  32'd0);
    checkField("rst.InReady",   32'(InReady),   32'd1);
    checkField("rst.Empty",     32'(Empty),     32'd1);
    @(negedge Clk);
    Reset = 1'b0;

    // Queue works again after a mid-drain reset
    v = mk(1, 6, 32'h66, 0, 6, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    @(negedge Clk);
    InValid = 1'b0;
    #1;
    checkField("post.Count",       32'(Count),    32'd1);
    checkField("post.Pending1",    32'(Pending1), 32'd1);
    checkField("post.BypassData1", BypassData1,   32'h66);
    checkField("post.Pending2",    32'(Pending2), 32'd0);
    @(negedge Clk);
    #1;
    checkField("post.RegWrite",  32'(RegWrite), 32'd1);
    checkField("post.WriteReg",  32'(WriteReg), 32'd6);
    checkField("post.WriteData", WriteData,     32'h66);
    @(negedge Clk);
    #1;
    checkField("post.Empty",     32'(Empty),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
